// File: rtl/maxpool_2x2_stream_if.sv
// maxpool_2x2_stream_if
//   Handshake bundle between a pixel producer and the 2x2 max-pool stage.
//   master : drives start_signal, pixel_valid, pixel_in; observes the results.
//   slave  : the pooling stage; drives result_valid, result_out, done_signal, busy.
interface maxpool_2x2_stream_if #(
  parameter int DATA_WIDTH = 22
);
  logic                         start_signal;
  logic                         pixel_valid;
  logic signed [DATA_WIDTH-1:0] pixel_in;
  logic                         result_valid;
  logic signed [DATA_WIDTH-1:0] result_out;
  logic                         done_signal;
  logic                         busy;

  modport master (
    output start_signal, pixel_valid, pixel_in,
    input  result_valid, result_out, done_signal, busy
  );

  modport slave (
    input  start_signal, pixel_valid, pixel_in,
    output result_valid, result_out, done_signal, busy
  );
endinterface

// File: rtl/maxpool_2x2_stream.sv
// maxpool_2x2_stream
//   Streaming 2x2 / stride-2 max-pool over a raster-order IMG_HEIGHT x IMG_WIDTH
//   map of signed pixels. Horizontal pairs are reduced on the fly; even-row
//   pair maxima are parked in a half-width line buffer and combined with the
//   odd-row pair maxima to form one pooled output per 2x2 window.
//
// Ports
//   clk      : rising-edge clock
//   rst      : asynchronous active-high reset
//   pool_if  : slave side of maxpool_2x2_stream_if
//              (start_signal, pixel_valid, pixel_in -> result_valid,
//               result_out, done_signal, busy)
//
// Build option
//   MAXPOOL_RELU_EN : when defined, negative pooled values are clamped to 0.
//
// FSM
//   state  | meaning
//   -------+-------------------------------------------------------------
//   S_IDLE | waiting for start_signal; pixel_valid ignored
//   S_RUN  | consuming a frame; leaves on acceptance of the last pixel
module maxpool_2x2_stream #(
  parameter int DATA_WIDTH = 22,
  parameter int IMG_WIDTH  = 30,
  parameter int IMG_HEIGHT = 30
) (
  input logic                 clk,
  input logic                 rst,
  maxpool_2x2_stream_if.slave pool_if
);

  localparam int COL_W = (IMG_WIDTH  > 2) ? $clog2(IMG_WIDTH)  : 1;
  localparam int ROW_W = (IMG_HEIGHT > 2) ? $clog2(IMG_HEIGHT) : 1;
  localparam int HALF  = IMG_WIDTH / 2;
  localparam int IDX_W = (HALF > 1) ? $clog2(HALF) : 1;
  localparam logic [COL_W-1:0] COL_LAST = COL_W'(IMG_WIDTH - 1);
  localparam logic [ROW_W-1:0] ROW_LAST = ROW_W'(IMG_HEIGHT - 1);

  typedef enum logic {S_IDLE, S_RUN} state_t;

  state_t                       state_q, state_d;
  logic [COL_W-1:0]             col_q, col_d;
  logic [ROW_W-1:0]             row_q, row_d;
  logic signed [DATA_WIDTH-1:0] h_first_q, h_first_d;
  logic signed [DATA_WIDTH-1:0] result_q, result_d;
  logic                         result_valid_q, result_valid_d;
  logic                         done_q, done_d;

  // Not reset: every entry is written on an even row before the odd row reads it.
  logic signed [DATA_WIDTH-1:0] line_buf_q [HALF];

  logic                         lb_we;
  logic [IDX_W-1:0]             lb_idx;
  logic signed [DATA_WIDTH-1:0] h_max;
  logic signed [DATA_WIDTH-1:0] lb_rd;
  logic signed [DATA_WIDTH-1:0] v_max;
  logic signed [DATA_WIDTH-1:0] pooled;

  assign lb_idx = IDX_W'(col_q >> 1);
  assign h_max  = (h_first_q >= pool_if.pixel_in) ? h_first_q : pool_if.pixel_in;
  assign lb_rd  = line_buf_q[lb_idx];
  assign v_max  = (lb_rd >= h_max) ? lb_rd : h_max;

`ifdef MAXPOOL_RELU_EN
  assign pooled = v_max[DATA_WIDTH-1] ? '0 : v_max;
`else
  assign pooled = v_max;
`endif

  always_comb begin
    state_d        = state_q;
    col_d          = col_q;
    row_d          = row_q;
    h_first_d      = h_first_q;
    result_d       = result_q;
    result_valid_d = 1'b0;
    done_d         = 1'b0;
    lb_we          = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (pool_if.start_signal) begin
          state_d = S_RUN;
          col_d   = '0;
          row_d   = '0;
        end
      end
      S_RUN: begin
        if (pool_if.pixel_valid) begin
          if (col_q == COL_LAST) begin
            col_d = '0;
            if (row_q == ROW_LAST) begin
              row_d   = '0;
              state_d = S_IDLE;
            end else begin
              row_d = row_q + ROW_W'(1);
            end
          end else begin
            col_d = col_q + COL_W'(1);
          end

          if (!col_q[0]) begin
            h_first_d = pool_if.pixel_in;
          end else if (!row_q[0]) begin
            lb_we = 1'b1;
          end else begin
            result_d       = pooled;
            result_valid_d = 1'b1;
            // The last pixel of the frame always closes the last window.
            done_d         = (col_q == COL_LAST) && (row_q == ROW_LAST);
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q        <= S_IDLE;
      col_q          <= '0;
      row_q          <= '0;
      h_first_q      <= '0;
      result_q       <= '0;
      result_valid_q <= 1'b0;
      done_q         <= 1'b0;
    end else begin
      state_q        <= state_d;
      col_q          <= col_d;
      row_q          <= row_d;
      h_first_q      <= h_first_d;
      result_q       <= result_d;
      result_valid_q <= result_valid_d;
      done_q         <= done_d;
    end
  end

  always_ff @(posedge clk) begin
    if (lb_we) begin
      line_buf_q[lb_idx] <= h_max;
    end
  end

  assign pool_if.result_valid = result_valid_q;
  assign pool_if.result_out   = result_q;
  assign pool_if.done_signal  = done_q;
  assign pool_if.busy         = (state_q == S_RUN);

endmodule

// File: tb/tb_maxpool_2x2_stream.sv
module tb_maxpool_2x2_stream;
  localparam int DW   = 22;
  localparam int W    = 30;
  localparam int H    = 30;
  localparam int NOUT = (W / 2) * (H / 2);

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  maxpool_2x2_stream_if #(.DATA_WIDTH(DW)) pif ();

  maxpool_2x2_stream #(.DATA_WIDTH(DW), .IMG_WIDTH(W), .IMG_HEIGHT(H)) dut (
    .clk     (clk),
    .rst     (rst),
    .pool_if (pif)
  );

  int tests_run    = 0;
  int tests_failed = 0;
  int cyc          = 0;

  int frame [H][W];
  int exp_q[$];
  int exp_cyc_q[$];
  int got_q[$];
  int got_cyc_q[$];
  bit got_done_q[$];
  int done_cnt;
  logic busy_at_start, busy_after_last;

  always @(posedge clk) cyc <= cyc + 1;

  // Output capture, 1 time unit after the active edge.
  always @(posedge clk) begin
    #1;
    if (pif.result_valid === 1'b1) begin
      got_q.push_back(int'(pif.result_out));
      got_cyc_q.push_back(cyc);
      got_done_q.push_back(pif.done_signal === 1'b1);
    end
    if (pif.done_signal === 1'b1) done_cnt++;
  end

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog");
  end

  // Reference: every 2x2 window reduced to its maximum, optional clamp.
  function automatic void build_expected();
    exp_q.delete();
    for (int i = 0; i < H / 2; i++)
      for (int j = 0; j < W / 2; j++) begin
        int m;
        m = frame[2*i][2*j];
        if (frame[2*i][2*j+1]   > m) m = frame[2*i][2*j+1];
        if (frame[2*i+1][2*j]   > m) m = frame[2*i+1][2*j];
        if (frame[2*i+1][2*j+1] > m) m = frame[2*i+1][2*j+1];
`ifdef MAXPOOL_RELU_EN
        if (m < 0) m = 0;
`endif
        exp_q.push_back(m);
      end
  endfunction

  function automatic int rand_pix();
    return int'($urandom_range(4194303)) - 2097152;
  endfunction

  function automatic void fill_ramp();
    for (int r = 0; r < H; r++)
      for (int c = 0; c < W; c++) frame[r][c] = r * W + c;
  endfunction

  function automatic void fill_random();
    for (int r = 0; r < H; r++)
      for (int c = 0; c < W; c++) frame[r][c] = rand_pix();
  endfunction

  function automatic int first_bad_val();
    int n;
    n = (got_q.size() < exp_q.size()) ? got_q.size() : exp_q.size();
    for (int k = 0; k < n; k++) if (got_q[k] != exp_q[k]) return k;
    if (got_q.size() != exp_q.size()) return n;
    return -1;
  endfunction

  function automatic int first_bad_cyc();
    int n;
    n = (got_cyc_q.size() < exp_cyc_q.size()) ? got_cyc_q.size() : exp_cyc_q.size();
    for (int k = 0; k < n; k++) if (got_cyc_q[k] != exp_cyc_q[k]) return k;
    if (got_cyc_q.size() != exp_cyc_q.size()) return n;
    return -1;
  endfunction

  function automatic int got_at(input int k);
    return (k >= 0 && k < got_q.size()) ? got_q[k] : -99999999;
  endfunction

  function automatic int exp_at(input int k);
    return (k >= 0 && k < exp_q.size()) ? exp_q[k] : -99999999;
  endfunction

  function automatic void clear_capture();
    got_q.delete();
    got_cyc_q.delete();
    got_done_q.delete();
    exp_cyc_q.delete();
    done_cnt = 0;
  endfunction

  // Starts at a falling edge: pulses start, then streams the frame.
  // start_at >= 0 additionally raises start_signal alongside that pixel.
  task automatic drive_frame(input int gap_pct, input int start_at);
    pif.start_signal = 1'b1;
    pif.pixel_valid  = 1'b0;
    @(negedge clk);
    pif.start_signal = 1'b0;
    busy_at_start = pif.busy;
    for (int r = 0; r < H; r++)
      for (int c = 0; c < W; c++) begin
        int gaps;
        gaps = 0;
        while (gap_pct > 0 && gaps < 8 && $urandom_range(99) < gap_pct) begin
          pif.pixel_valid  = 1'b0;
          pif.start_signal = 1'b0;
          pif.pixel_in     = DW'($urandom);
          @(negedge clk);
          gaps++;
        end
        pif.pixel_valid  = 1'b1;
        pif.pixel_in     = DW'(frame[r][c]);
        pif.start_signal = ((r * W + c) == start_at);
        if ((r % 2 == 1) && (c % 2 == 1)) exp_cyc_q.push_back(cyc + 1);
        @(negedge clk);
      end
    pif.pixel_valid  = 1'b0;
    pif.start_signal = 1'b0;
    busy_after_last  = pif.busy;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    pif.start_signal = 1'b0;
    pif.pixel_valid  = 1'b0;
    pif.pixel_in     = '0;
    repeat (3) @(negedge clk);
    tests_run++;
    if (pif.result_valid !== 1'b0 || pif.result_out !== '0 ||
        pif.done_signal !== 1'b0 || pif.busy !== 1'b0) begin
      tests_failed++;
      $display("FAIL reset_outputs got valid=%b out=%0d done=%b busy=%b, required all 0",
               pif.result_valid, pif.result_out, pif.done_signal, pif.busy);
    end
    rst = 1'b0;
    repeat (2) @(negedge clk);
    tests_run++;
    if (pif.busy !== 1'b0 || pif.result_valid !== 1'b0) begin
      tests_failed++;
      $display("FAIL post_reset_idle got busy=%b valid=%b, required 0 0", pif.busy, pif.result_valid);
    end
  endtask

  task automatic test_ramp();
    int k;
    fill_ramp();
    build_expected();
    clear_capture();
    drive_frame(0, -1);
    repeat (3) @(negedge clk);
    tests_run++;
    if (got_q.size() !== NOUT) begin
      tests_failed++;
      $display("FAIL ramp_count got %0d, required %0d", got_q.size(), NOUT);
    end
    k = first_bad_val();
    tests_run++;
    if (k !== -1) begin
      tests_failed++;
      $display("FAIL ramp_values idx=%0d got %0d, required %0d", k, got_at(k), exp_at(k));
    end
    tests_run++;
    if (got_at(0) !== 31 || got_at(NOUT - 1) !== 899) begin
      tests_failed++;
      $display("FAIL ramp_ends got first=%0d last=%0d, required 31 899", got_at(0), got_at(NOUT - 1));
    end
    tests_run++;
    if (done_cnt !== 1 || got_done_q.size() == 0 || got_done_q[got_done_q.size() - 1] !== 1'b1) begin
      tests_failed++;
      $display("FAIL ramp_done got count=%0d, required 1 on last output", done_cnt);
    end
    tests_run++;
    if (busy_at_start !== 1'b1 || busy_after_last !== 1'b0) begin
      tests_failed++;
      $display("FAIL ramp_busy got rise=%b fall=%b, required 1 0", busy_at_start, busy_after_last);
    end
    k = first_bad_cyc();
    tests_run++;
    if (k !== -1) begin
      tests_failed++;
      $display("FAIL ramp_latency idx=%0d, required 1 cycle after window", k);
    end
  endtask

  task automatic test_negative();
    int k;
    for (int r = 0; r < H; r++)
      for (int c = 0; c < W; c++) frame[r][c] = -5;
    frame[1][1] = -1;
    build_expected();
    clear_capture();
    drive_frame(0, -1);
    repeat (3) @(negedge clk);
    k = first_bad_val();
    tests_run++;
    if (k !== -1) begin
      tests_failed++;
      $display("FAIL negative_values idx=%0d got %0d, required %0d", k, got_at(k), exp_at(k));
    end
    tests_run++;
`ifdef MAXPOOL_RELU_EN
    if (got_at(0) !== 0 || got_at(1) !== 0) begin
      tests_failed++;
      $display("FAIL negative_first got %0d %0d, required 0 0", got_at(0), got_at(1));
    end
`else
    if (got_at(0) !== -1 || got_at(1) !== -5) begin
      tests_failed++;
      $display("FAIL negative_first got %0d %0d, required -1 -5", got_at(0), got_at(1));
    end
`endif
  endtask

  task automatic test_extreme();
    int k;
    fill_random();
    frame[0][0] = -2097152;
    frame[0][1] = 2097151;
    frame[1][0] = 0;
    frame[1][1] = -1;
    build_expected();
    clear_capture();
    drive_frame(0, -1);
    repeat (3) @(negedge clk);
    tests_run++;
    if (got_at(0) !== 2097151) begin
      tests_failed++;
      $display("FAIL extreme_window got %0d, required 2097151", got_at(0));
    end
    k = first_bad_val();
    tests_run++;
    if (k !== -1) begin
      tests_failed++;
      $display("FAIL extreme_random idx=%0d got %0d, required %0d", k, got_at(k), exp_at(k));
    end
  endtask

  task automatic test_random_gaps();
    int k;
    fill_ramp();
    build_expected();
    clear_capture();
    drive_frame(50, -1);
    repeat (3) @(negedge clk);
    k = first_bad_val();
    tests_run++;
    if (k !== -1) begin
      tests_failed++;
      $display("FAIL gaps_values idx=%0d got %0d, required %0d", k, got_at(k), exp_at(k));
    end
    k = first_bad_cyc();
    tests_run++;
    if (k !== -1) begin
      tests_failed++;
      $display("FAIL gaps_latency idx=%0d, required 1 cycle after window", k);
    end
    tests_run++;
    if (done_cnt !== 1) begin
      tests_failed++;
      $display("FAIL gaps_done got %0d pulses, required 1", done_cnt);
    end
  endtask

  task automatic test_ignored();
    int k;
    clear_capture();
    for (int i = 0; i < 12; i++) begin
      pif.pixel_valid = 1'b1;
      pif.pixel_in    = DW'($urandom);
      @(negedge clk);
    end
    pif.pixel_valid = 1'b0;
    repeat (3) @(negedge clk);
    tests_run++;
    if (got_q.size() !== 0 || pif.busy !== 1'b0) begin
      tests_failed++;
      $display("FAIL idle_pixels got outputs=%0d busy=%b, required 0 0", got_q.size(), pif.busy);
    end
    fill_random();
    build_expected();
    clear_capture();
    drive_frame(20, 400);
    repeat (3) @(negedge clk);
    k = first_bad_val();
    tests_run++;
    if (k !== -1) begin
      tests_failed++;
      $display("FAIL start_mid_frame idx=%0d got %0d, required %0d", k, got_at(k), exp_at(k));
    end
    tests_run++;
    if (done_cnt !== 1) begin
      tests_failed++;
      $display("FAIL start_mid_done got %0d pulses, required 1", done_cnt);
    end
  endtask

  task automatic test_reset_mid();
    int k;
    fill_ramp();
    clear_capture();
    pif.start_signal = 1'b1;
    @(negedge clk);
    pif.start_signal = 1'b0;
    for (int idx = 0; idx < 500; idx++) begin
      pif.pixel_valid = 1'b1;
      pif.pixel_in    = DW'(frame[idx / W][idx % W]);
      @(negedge clk);
    end
    pif.pixel_valid = 1'b0;
    #2;
    rst = 1'b1;
    #1;
    tests_run++;
    if (pif.result_valid !== 1'b0 || pif.result_out !== '0 ||
        pif.done_signal !== 1'b0 || pif.busy !== 1'b0) begin
      tests_failed++;
      $display("FAIL midframe_reset got valid=%b out=%0d done=%b busy=%b, required all 0",
               pif.result_valid, pif.result_out, pif.done_signal, pif.busy);
    end
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    fill_random();
    build_expected();
    clear_capture();
    drive_frame(0, -1);
    repeat (3) @(negedge clk);
    k = first_bad_val();
    tests_run++;
    if (k !== -1) begin
      tests_failed++;
      $display("FAIL after_reset_values idx=%0d got %0d, required %0d", k, got_at(k), exp_at(k));
    end
  endtask

  task automatic test_back_to_back();
    int k;
    fill_random();
    build_expected();
    clear_capture();
    // start coincident with the final pixel must be ignored
    drive_frame(0, W * H - 1);
    tests_run++;
    if (busy_after_last !== 1'b0) begin
      tests_failed++;
      $display("FAIL start_on_last got busy=%b, required 0", busy_after_last);
    end
    k = first_bad_val();
    tests_run++;
    if (k !== -1 || done_cnt !== 1) begin
      tests_failed++;
      $display("FAIL b2b_first idx=%0d got %0d, required %0d (done=%0d)", k, got_at(k), exp_at(k), done_cnt);
    end
    // next start issued in the done cycle itself
    fill_random();
    build_expected();
    clear_capture();
    drive_frame(0, -1);
    repeat (3) @(negedge clk);
    k = first_bad_val();
    tests_run++;
    if (k !== -1) begin
      tests_failed++;
      $display("FAIL b2b_second idx=%0d got %0d, required %0d", k, got_at(k), exp_at(k));
    end
    k = first_bad_cyc();
    tests_run++;
    if (k !== -1 || busy_at_start !== 1'b1) begin
      tests_failed++;
      $display("FAIL b2b_timing idx=%0d busy_rise=%b, required -1 1", k, busy_at_start);
    end
  endtask

  initial begin
    test_reset();
    test_ramp();
    test_negative();
    test_extreme();
    test_random_gaps();
    test_ignored();
    test_reset_mid();
    test_back_to_back();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
